// File: rtl/dmi_req_sequencer_if.sv
// DMI request/response channel between the sequencer (master) and the Debug Module (slave).
// Request word {addr, op, data}; response word {data, resp}.
interface dmi_req_sequencer_if #(
   parameter int ABITS = 7
);
   logic               req_valid;
   logic               req_ready;
   logic [ABITS+33:0]  req;
   logic               resp_valid;
   logic               resp_ready;
   logic [33:0]        resp;

   modport master (
      output req_valid, req, resp_ready,
      input  req_ready, resp_valid, resp
   );

   modport slave (
      input  req_valid, req, resp_ready,
      output req_ready, resp_valid, resp
   );
endinterface

// File: rtl/dmi_req_sequencer.sv
// TAP-to-DMI sequencer: one DMI handshake per held TAP request, 1-cycle done pulse, sticky error.
// Capture->req_valid 1 cycle, resp->done 1 cycle; waits on DM backpressure (timeout abort when DMI_REQ_SEQUENCER_TIMEOUT_EN).
module dmi_req_sequencer #(
   parameter int ABITS          = 7,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                 CLK_I,
   input  logic                 RST_I,
   input  logic                 TAP_READ_I,
   input  logic                 TAP_WRITE_I,
   input  logic [ABITS+33:0]    TAP_DMI_I,
   output logic [ABITS+33:0]    TAP_DMI_O,
   output logic                 TAP_DONE_O,
   input  logic                 HARD_RESET_I,
   input  logic                 ERR_CLR_I,
   output logic [1:0]           DMI_ERROR_O,
   dmi_req_sequencer_if.master  dmi
);

   localparam int W = ABITS + 34;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_RESP,
      ST_DONE,
      ST_RELEASE
   } state_t;

   state_t          state;
   logic [W-1:0]    req_q;
   logic [W-1:0]    tap_q;
   logic            req_vld_q;
   logic            resp_rdy_q;
   logic            done_q;
   logic [1:0]      err_q;
   logic [1:0]      err_set;
   logic            abort;
   logic [1:0]      tap_op_unused;

   assign tap_op_unused = TAP_DMI_I[33:32];

`ifdef DMI_REQ_SEQUENCER_TIMEOUT_EN
   localparam int            TW   = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] timer_q;
   logic          waiting;
   logic          timeout_hit;

   assign waiting     = (state == ST_REQ) || (state == ST_RESP);
   assign timeout_hit = waiting && (timer_q == TMAX);
   // A handshake in the final cycle still counts as accepted.
   assign abort       = timeout_hit &&
                        !((state == ST_REQ)  && dmi.req_ready) &&
                        !((state == ST_RESP) && dmi.resp_valid);

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         timer_q <= '0;
      end else if (HARD_RESET_I) begin
         timer_q <= '0;
      end else if (((state == ST_REQ && !dmi.req_ready) ||
                    (state == ST_RESP && !dmi.resp_valid)) && !timeout_hit) begin
         timer_q <= timer_q + 1'b1;
      end else begin
         timer_q <= '0;
      end
   end
`else
   localparam int TIMEOUT_CYCLES_UNUSED = TIMEOUT_CYCLES;

   assign abort = 1'b0;
`endif

   always_comb begin
      err_set = 2'd0;
      if (state == ST_RESP && dmi.resp_valid && dmi.resp[1]) begin
         err_set = dmi.resp[1:0];
      end else if (abort) begin
         err_set = 2'd3;
      end
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state      <= ST_IDLE;
         req_q      <= '0;
         tap_q      <= '0;
         req_vld_q  <= 1'b0;
         resp_rdy_q <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 2'd0;
      end else if (HARD_RESET_I) begin
         state      <= ST_IDLE;
         req_vld_q  <= 1'b0;
         resp_rdy_q <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 2'd0;
      end else begin
         done_q <= 1'b0;

         // First error sticks; a same-cycle clear beats a set.
         if (ERR_CLR_I) begin
            err_q <= 2'd0;
         end else if (err_q == 2'd0 && err_set != 2'd0) begin
            err_q <= err_set;
         end

         case (state)
            ST_IDLE: begin
               if (TAP_WRITE_I || TAP_READ_I) begin
                  req_q      <= {TAP_DMI_I[W-1:34],
                                 TAP_WRITE_I ? 2'd2 : 2'd1,
                                 TAP_WRITE_I ? TAP_DMI_I[31:0] : 32'd0};
                  req_vld_q  <= 1'b1;
                  resp_rdy_q <= 1'b0;
                  state      <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (dmi.req_ready) begin
                  req_vld_q  <= 1'b0;
                  resp_rdy_q <= 1'b1;
                  state      <= ST_RESP;
               end else if (abort) begin
                  req_vld_q  <= 1'b0;
                  resp_rdy_q <= 1'b1;
                  tap_q      <= {req_q[W-1:34], 2'd3, 32'd0};
                  done_q     <= 1'b1;
                  state      <= ST_DONE;
               end
            end
            ST_RESP: begin
               if (dmi.resp_valid) begin
                  tap_q  <= {req_q[W-1:34], dmi.resp[1:0], dmi.resp[33:2]};
                  done_q <= 1'b1;
                  state  <= ST_DONE;
               end else if (abort) begin
                  tap_q  <= {req_q[W-1:34], 2'd3, 32'd0};
                  done_q <= 1'b1;
                  state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_RELEASE;
            end
            ST_RELEASE: begin
               // Held requests are not reissued; wait for the TAP to let go.
               if (!TAP_READ_I && !TAP_WRITE_I) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign dmi.req_valid  = req_vld_q;
   assign dmi.req        = req_q;
   assign dmi.resp_ready = resp_rdy_q;
   assign TAP_DMI_O      = tap_q;
   assign TAP_DONE_O     = done_q;
   assign DMI_ERROR_O    = err_q;

endmodule

// File: tb/tb_dmi_req_sequencer.sv
// Randomized scoreboard bench for dmi_req_sequencer; DM side and TAP side driven by one process, monitor checks.
module tb_dmi_req_sequencer;

   localparam int ABITS = 7;
   localparam int W     = ABITS + 34;

   typedef struct {
      logic [W-1:0] dmi;
      logic [1:0]   err;
   } done_exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tap_read = 1'b0;
   logic          tap_write = 1'b0;
   logic [W-1:0]  tap_dmi_i = '0;
   logic [W-1:0]  tap_dmi_o;
   logic          tap_done;
   logic          hard_reset = 1'b0;
   logic          err_clr = 1'b0;
   logic [1:0]    dmi_error;

   dmi_req_sequencer_if #(.ABITS(ABITS)) dmi ();

   dmi_req_sequencer #(.ABITS(ABITS), .TIMEOUT_CYCLES(16)) dut (
      .CLK_I        (clk),
      .RST_I        (rst),
      .TAP_READ_I   (tap_read),
      .TAP_WRITE_I  (tap_write),
      .TAP_DMI_I    (tap_dmi_i),
      .TAP_DMI_O    (tap_dmi_o),
      .TAP_DONE_O   (tap_done),
      .HARD_RESET_I (hard_reset),
      .ERR_CLR_I    (err_clr),
      .DMI_ERROR_O  (dmi_error),
      .dmi          (dmi)
   );

   always #5 clk = ~clk;

   int           vectors = 0;
   int           miscompares = 0;
   bit           mon_en = 1'b0;
   logic [1:0]   err_model = 2'd0;
   logic [W-1:0] exp_req_q[$];
   done_exp_t    exp_done_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic fail_event(input string name, input logic [63:0] act);
      vectors++;
      miscompares++;
      $display("FAIL %s: got %0h, required nothing", name, act);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops expectations whenever the DUT presents a request handshake or a done pulse.
   logic         prev_vld = 1'b0;
   logic         prev_hs = 1'b0;
   logic [W-1:0] prev_req = '0;
   done_exp_t    mon_e;

   always @(negedge clk) begin
      if (mon_en) begin
         if (prev_vld && !prev_hs && dmi.req_valid)
            check("req_stable", 64'(dmi.req), 64'(prev_req));
         if (dmi.req_valid && dmi.req_ready) begin
            if (exp_req_q.size() == 0) fail_event("unexpected_req", 64'(dmi.req));
            else check("dmi_req", 64'(dmi.req), 64'(exp_req_q.pop_front()));
         end
         if (tap_done) begin
            if (exp_done_q.size() == 0) begin
               fail_event("unexpected_done", 64'(tap_dmi_o));
            end else begin
               mon_e = exp_done_q.pop_front();
               check("tap_dmi", 64'(tap_dmi_o), 64'(mon_e.dmi));
               check("dmi_error", 64'(dmi_error), 64'(mon_e.err));
            end
         end
         prev_vld = dmi.req_valid;
         prev_hs  = dmi.req_valid && dmi.req_ready;
         prev_req = dmi.req;
      end else begin
         prev_vld = 1'b0;
      end
   end

   task automatic run_txn(input bit wr, input bit both, input logic [ABITS-1:0] addr,
                          input logic [31:0] wdata, input int rdy_dly, input int rsp_dly,
                          input logic [1:0] code, input logic [31:0] rdata,
                          input int hold, input bit clr);
      int        cnt;
      done_exp_t e;
      exp_req_q.push_back({addr, wr ? 2'd2 : 2'd1, wr ? wdata : 32'd0});
      if (clr) err_model = 2'd0;
      else if (err_model == 2'd0 && code >= 2'd2) err_model = code;
      e.dmi = {addr, code, rdata};
      e.err = err_model;
      exp_done_q.push_back(e);

      tap_dmi_i = {addr, 2'($urandom), wdata};
      tap_write = wr;
      tap_read  = !wr || both;
      dmi.req_ready = 1'b0;
      tick();
      check("req_latency", 64'(dmi.req_valid), 64'd1);
      cnt = int'(dmi.req_valid);
      repeat (rdy_dly) begin
         tick();
         cnt += int'(dmi.req_valid);
      end
      dmi.req_ready = 1'b1;
      tick();
      dmi.req_ready = 1'b0;
      check("valid_cycles", 64'(cnt), 64'(rdy_dly + 1));
      check("valid_drop", 64'(dmi.req_valid), 64'd0);
      repeat (rsp_dly) tick();
      dmi.resp_valid = 1'b1;
      dmi.resp = {rdata, code};
      err_clr = clr;
      tick();
      dmi.resp_valid = 1'b0;
      dmi.resp = 34'($urandom);
      err_clr = 1'b0;
      repeat (hold) tick();
      tap_read  = 1'b0;
      tap_write = 1'b0;
      repeat (2) tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      int          r;
      int          cnt;
      int          n;
      done_exp_t   e;
      logic [1:0]  code;

      dmi.req_ready  = 1'b0;
      dmi.resp_valid = 1'b0;
      dmi.resp       = '0;

      #12;
      check("rst_req_valid", 64'(dmi.req_valid), 64'd0);
      check("rst_resp_ready", 64'(dmi.resp_ready), 64'd1);
      check("rst_done", 64'(tap_done), 64'd0);
      check("rst_error", 64'(dmi_error), 64'd0);
      check("rst_tap_dmi", 64'(tap_dmi_o), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      mon_en = 1'b1;
      tick();

      // Basic read and backpressured write with extra hold.
      run_txn(1'b0, 1'b0, 7'h11, 32'h0, 0, 0, 2'd0, 32'hDEADBEEF, 0, 1'b0);
      run_txn(1'b1, 1'b0, 7'h04, 32'h12345678, 5, 1, 2'd0, 32'h0BADF00D, 3, 1'b0);

      // Sticky error sequence.
      run_txn(1'b0, 1'b0, 7'h20, 32'h0, 0, 0, 2'd2, 32'h1, 0, 1'b0);
      run_txn(1'b0, 1'b0, 7'h21, 32'h0, 1, 0, 2'd3, 32'h2, 0, 1'b0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      err_model = 2'd0;
      check("err_clear", 64'(dmi_error), 64'd0);
      run_txn(1'b1, 1'b0, 7'h22, 32'h55, 0, 2, 2'd3, 32'h3, 1, 1'b1);

      // Hard reset mid-RESP with the error sticky at 2.
      run_txn(1'b0, 1'b0, 7'h30, 32'h0, 0, 0, 2'd2, 32'h4, 0, 1'b0);
      exp_req_q.push_back({7'h31, 2'd1, 32'd0});
      tap_dmi_i = {7'h31, 2'd0, 32'hFFFF};
      tap_read = 1'b1;
      tick();
      dmi.req_ready = 1'b1;
      tick();
      dmi.req_ready = 1'b0;
      tick();
      hard_reset = 1'b1;
      tap_read = 1'b0;
      tick();
      hard_reset = 1'b0;
      err_model = 2'd0;
      check("hr_req_valid", 64'(dmi.req_valid), 64'd0);
      check("hr_done", 64'(tap_done), 64'd0);
      check("hr_error", 64'(dmi_error), 64'd0);
      check("hr_resp_ready", 64'(dmi.resp_ready), 64'd1);
      repeat (4) tick();
      run_txn(1'b0, 1'b0, 7'h32, 32'h0, 1, 1, 2'd0, 32'hA5A5A5A5, 0, 1'b0);

`ifdef DMI_REQ_SEQUENCER_TIMEOUT_EN
      // DM never accepts: abort after 16 REQ cycles, late response ignored.
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      err_model = 2'd3;
      e.dmi = {7'h05, 2'd3, 32'd0};
      e.err = 2'd3;
      exp_done_q.push_back(e);
      tap_dmi_i = {7'h05, 2'd2, 32'hCAFE0001};
      tap_write = 1'b1;
      tick();
      cnt = 0;
      n = 0;
      while (dmi.req_valid && n < 100) begin
         cnt++;
         n++;
         tick();
      end
      check("timeout_valid_cycles", 64'(cnt), 64'd16);
      tick();
      dmi.resp_valid = 1'b1;
      dmi.resp = {32'h1234, 2'd0};
      tick();
      dmi.resp_valid = 1'b0;
      tap_write = 1'b0;
      repeat (4) tick();
      check("timeout_err_sticky", 64'(dmi_error), 64'd3);
`endif

      // Randomized traffic.
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         code = (r < 6) ? 2'd0 : (r < 7) ? 2'd1 : (r < 8) ? 2'd2 : 2'd3;
         run_txn(1'($urandom), 1'($urandom), 7'($urandom), $urandom,
                 $urandom_range(0, 5), $urandom_range(0, 4), code, $urandom,
                 $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 7) == 0) begin
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            err_model = 2'd0;
         end
      end

      // Async reset asserted between edges while in REQ.
      exp_req_q.push_back({7'h40, 2'd1, 32'd0});
      tap_dmi_i = {7'h40, 2'd0, 32'h0};
      tap_read = 1'b1;
      tick();
      #2;
      rst = 1'b1;
      mon_en = 1'b0;
      #1;
      check("ar_req_valid", 64'(dmi.req_valid), 64'd0);
      check("ar_resp_ready", 64'(dmi.resp_ready), 64'd1);
      check("ar_done", 64'(tap_done), 64'd0);
      check("ar_error", 64'(dmi_error), 64'd0);
      check("ar_tap_dmi", 64'(tap_dmi_o), 64'd0);
      exp_req_q.delete();
      exp_done_q.delete();
      tap_read = 1'b0;
      err_model = 2'd0;
      @(posedge clk);
      #1 rst = 1'b0;
      mon_en = 1'b1;
      tick();
      run_txn(1'b1, 1'b0, 7'h41, 32'h77, 0, 0, 2'd0, 32'h88, 0, 1'b0);

      repeat (3) tick();
      check("req_q_drained", 64'(exp_req_q.size()), 64'd0);
      check("done_q_drained", 64'(exp_done_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
